// File: rtl/filtered_tx_pkg.sv
// Shared types and defaults for the filtered_tx SPI slave transmitter.
// Optional build macro used by the top level: FILTERED_TX_DROP_CNT_EN.
`timescale 1ns/1ps
package filtered_tx_pkg;

    localparam int DEFAULT_DATA_W      = 16;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Saturating 8-bit increment used by the dropped-sample counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/filtered_tx_sample_fifo.sv
// sample_fifo: power-of-two circular buffer holding filtered samples
// waiting to be shifted out. Pointers wrap naturally on their bit width.
`timescale 1ns/1ps
module sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s, do_pop_s;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == CW'(0));
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop together keeps the count.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/filtered_tx.sv
// filtered_tx: buffers filtered samples and shifts them out MSB first as an
// SPI mode-0 slave. SCK and CS are synchronised into clk before use.
// Optional macro FILTERED_TX_DROP_CNT_EN adds the saturating drop_cnt port.
`timescale 1ns/1ps
module filtered_tx
    import filtered_tx_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    output logic                          spi_miso,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_done
`ifdef FILTERED_TX_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, cs_prev_q;
    logic                   sck_s, cs_s;
    logic                   sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   underrun_q, underrun_d;
    logic                   miso_q, miso_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;

    logic                   push_s, pop_s;
    logic                   fifo_full_s, fifo_empty_s;
    logic [DATA_W-1:0]      fifo_head_s;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (din),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign cs_rise_s  = cs_s & ~cs_prev_q;
    assign cs_fall_s  = ~cs_s & cs_prev_q;

    // Ready depends only on registered occupancy; a full FIFO drops the sample.
    assign din_ready  = ~fifo_full_s;
    assign push_s     = din_valid & ~fifo_full_s;
    assign overflow_d = overflow_q | (din_valid & fifo_full_s);

    assign spi_miso   = miso_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // Synchronizer chains plus previous-value taps for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    // Frame FSM next state: load on CS fall, shift on SCK fall, count on SCK rise.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        underrun_d   = underrun_q;
        pop_s        = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                shift_d = '0;
                cnt_d   = '0;
                if (cs_fall_s) begin
                    state_d    = SHIFT;
                    underrun_d = fifo_empty_s;
                    shift_d    = fifo_empty_s ? '0 : fifo_head_s;
                end else begin
                    state_d    = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise_s) begin
                    // Aborted frame: the word stays in the FIFO for a retry.
                    state_d = IDLE;
                end else if (sck_fall_s) begin
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                end else if (sck_rise_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (cs_rise_s) begin
                    pop_s        = ~underrun_q;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // MISO tracks the next shift MSB, forced low while synchronised CS is high.
        if (cs_sync_d[SYNC_STAGES-1]) begin
            miso_d = 1'b0;
        end else begin
            miso_d = shift_d[DATA_W-1];
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            underrun_q   <= 1'b0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef FILTERED_TX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt_d = (din_valid & fifo_full_s) ? sat_inc8(drop_cnt_q) : drop_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    // Saturating count of samples dropped on a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_filtered_tx.sv
// Self-checking bench for filtered_tx: a queue model of the sample buffer
// is compared with bits captured by an SPI mode-0 master.
`timescale 1ns/1ps
module tb_filtered_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_miso;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          frame_done;
`ifdef FILTERED_TX_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            fd_cnt  = 0;
    int unsigned   half_ns = 60;
    logic [DW-1:0] model_q [$];
    bit            model_ovf = 1'b0;
    int            model_drops = 0;

    filtered_tx #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done)
`ifdef FILTERED_TX_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic push_sample(input logic [DW-1:0] v);
        @(negedge clk);
        din       = v;
        din_valid = 1'b1;
        if (model_q.size() < DEPTH) begin
            model_q.push_back(v);
        end else begin
            model_ovf = 1'b1;
            if (model_drops < 255) model_drops++;
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Expected word of a complete frame; removes the head from the model.
    task automatic model_full_frame(output logic [DW-1:0] exp);
        if (model_q.size() > 0) exp = model_q.pop_front();
        else exp = '0;
    endtask

    // SPI master: nbits clocks, then CS high. Optionally pushes pv timed to
    // land on the pop cycle and reports whether fifo_level held steady.
    task automatic spi_frame(input int nbits, input bit push_at_end, input logic [DW-1:0] pv,
                             output logic [DW-1:0] rx, output bit steady);
        logic [2:0] lvl0;
        rx     = '0;
        steady = 1'b1;
        half_ns = $urandom_range(60, 90);
        @(negedge clk);
        spi_cs_n = 1'b0;
        #(half_ns);
        for (int i = 0; i < nbits; i++) begin
            spi_sck = 1'b1;
            rx = {rx[DW-2:0], spi_miso};
            #(half_ns);
            spi_sck = 1'b0;
            #(half_ns);
        end
        @(negedge clk);
        spi_cs_n = 1'b1;
        lvl0 = fifo_level;
        if (push_at_end) begin
            repeat (SS) begin
                @(negedge clk);
                if (fifo_level !== lvl0) steady = 1'b0;
            end
            din       = pv;
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            if (fifo_level !== lvl0) steady = 1'b0;
        end
        repeat (12) begin
            @(negedge clk);
            if (fifo_level !== lvl0 && push_at_end) steady = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; din = '0; din_valid = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1;
        #23;
        n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got %b exp 1", din_ready); end
        n_tests++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] rx, exp;
        bit st;
        int fd0;
        push_sample(16'hA5C3);
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL basic_level_pre got %0d exp 1", fifo_level); end
        fd0 = fd_cnt;
        spi_frame(DW, 1'b0, '0, rx, st);
        model_full_frame(exp);
        n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL basic_miso got %h exp %h", rx, exp); end
        n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL basic_frame_done got %0d pulses exp 1", fd_cnt - fd0); end
        n_tests++; if (fifo_level !== 3'(model_q.size())) begin n_fail++; $display("FAIL basic_level_post got %0d exp %0d", fifo_level, model_q.size()); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] rx, exp;
        bit st;
        for (int i = 0; i < DEPTH + 1; i++) push_sample(16'($urandom));
        n_tests++; if (fifo_level !== 3'(model_q.size())) begin n_fail++; $display("FAIL ovf_level got %0d exp %0d", fifo_level, model_q.size()); end
        n_tests++; if (overflow !== model_ovf) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", overflow, model_ovf); end
        n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_din_ready got %b exp 0", din_ready); end
`ifdef FILTERED_TX_DROP_CNT_EN
        n_tests++; if (drop_cnt !== 8'(model_drops)) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d exp %0d", drop_cnt, model_drops); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            spi_frame(DW, 1'b0, '0, rx, st);
            model_full_frame(exp);
            n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL ovf_drain%0d got %h exp %h", i, rx, exp); end
        end
    endtask

    task automatic test_underrun();
        logic [DW-1:0] rx;
        bit st;
        int fd0;
        fd0 = fd_cnt;
        spi_frame(DW, 1'b0, '0, rx, st);
        n_tests++; if (rx !== 16'h0000) begin n_fail++; $display("FAIL underrun_miso got %h exp 0000", rx); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL underrun_level got %0d exp 0", fifo_level); end
        n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL underrun_frame_done got %0d exp 1", fd_cnt - fd0); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] rx, exp;
        bit st;
        int fd0;
        push_sample(16'h1234);
        fd0 = fd_cnt;
        spi_frame(7, 1'b0, '0, rx, st);
        exp = model_q[0] >> (DW - 7);
        n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL abort_bits got %h exp %h", rx, exp); end
        n_tests++; if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL abort_frame_done got %0d exp 0", fd_cnt - fd0); end
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL abort_level got %0d exp 1", fifo_level); end
        spi_frame(DW, 1'b0, '0, rx, st);
        model_full_frame(exp);
        n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL abort_retx got %h exp %h", rx, exp); end
        n_tests++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL abort_retx_done got %0d exp 1", fd_cnt - fd0); end
    endtask

    task automatic test_push_pop_same();
        logic [DW-1:0] rx, exp, pv;
        bit st;
        push_sample(16'($urandom));
        push_sample(16'($urandom));
        pv = 16'($urandom);
        spi_frame(DW, 1'b1, pv, rx, st);
        model_full_frame(exp);
        model_q.push_back(pv);
        n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL pp_miso got %h exp %h", rx, exp); end
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL pp_level_steady got %b exp 1", st); end
        n_tests++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL pp_level got %0d exp 2", fifo_level); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] rx, exp;
        bit st;
        int pushed = 0;
        while (pushed < 3 * DEPTH || model_q.size() > 0) begin
            if (pushed < 3 * DEPTH) begin
                push_sample(16'($urandom)); pushed++;
                if (model_q.size() <= 2 && pushed < 3 * DEPTH && $urandom_range(0, 1) == 1) begin
                    push_sample(16'($urandom)); pushed++;
                end
            end
            spi_frame(DW, 1'b0, '0, rx, st);
            model_full_frame(exp);
            n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL wrap_data got %h exp %h", rx, exp); end
        end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL wrap_level got %0d exp 0", fifo_level); end
        n_tests++; if (overflow !== model_ovf) begin n_fail++; $display("FAIL wrap_sticky_ovf got %b exp %b", overflow, model_ovf); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rx;
        bit st;
        push_sample(16'($urandom) | 16'h8000);
        push_sample(16'($urandom));
        @(negedge clk);
        spi_cs_n = 1'b0;
        #(half_ns);
        for (int i = 0; i < 9; i++) begin
            spi_sck = 1'b1; #(half_ns);
            if (i < 8) begin spi_sck = 1'b0; #(half_ns); end
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL mid_din_ready got %b exp 1", din_ready); end
        n_tests++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL mid_miso got %b exp 0", spi_miso); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow got %b exp 0", overflow); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_frame_done got %b exp 0", frame_done); end
        spi_sck = 1'b0; spi_cs_n = 1'b1;
        #50;
        @(negedge clk);
        reset_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        model_drops = 0;
        repeat (5) @(negedge clk);
`ifdef FILTERED_TX_DROP_CNT_EN
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_drop_cnt got %0d exp 0", drop_cnt); end
`endif
        spi_frame(DW, 1'b0, '0, rx, st);
        n_tests++; if (rx !== 16'h0000) begin n_fail++; $display("FAIL mid_next_frame got %h exp 0000", rx); end
        n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_next_level got %0d exp 0", fifo_level); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_underrun();
        test_abort();
        test_push_pop_same();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filtered_tx.md
FILTERED_TX -- requirements
Module: filtered_tx

Interface
REQ-001 Parameter DATA_W, default 16, sets the filtered-sample word width.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the sample buffer depth; it SHALL be a power of two and at least 2.
REQ-003 Parameter SYNC_STAGES, default 2, sets the flip-flop depth of the SCK and CS synchronizers; it SHALL be at least 2.
REQ-004 clk  input  1  is the single system clock; all state is on the rising edge.
REQ-005 reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 din  input  DATA_W  carries the filtered sample from the Kalman stage, MSB first on the wire.
REQ-007 din_valid  input  1  marks din as valid for one cycle.
REQ-008 din_ready  output  1  is high when the FIFO can accept a sample.
REQ-009 spi_sck  input  1  is the SPI master clock (mode 0), asynchronous to clk.
REQ-010 spi_cs_n  input  1  is the SPI master chip select, active-low, asynchronous to clk.
REQ-011 spi_miso  output  1  carries the serial data out.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  gives the current number of stored samples.
REQ-013 overflow  output  1  is a sticky flag that is set when a sample is dropped.
REQ-014 frame_done  output  1  is a one-cycle pulse when a full word has been shifted out.

Function
REQ-015 spi_sck and spi_cs_n SHALL each pass through a SYNC_STAGES flip-flop chain before any use; edges SHALL be detected on the synchronized values.
REQ-016 A sample SHALL be pushed when din_valid and din_ready are both high; din_ready SHALL equal not-full, computed from registered state only.
REQ-017 When din_valid is high and the FIFO is full, the sample SHALL be dropped, overflow SHALL be set, and fifo_level SHALL not change.
REQ-018 The state machine SHALL have the states IDLE, SHIFT and DONE.
REQ-019 In IDLE, a synchronized CS falling edge SHALL load the FIFO head into the shift register and enter SHIFT; if the FIFO is empty, all zeros SHALL be loaded and the frame flagged as an underrun.
REQ-020 spi_miso SHALL present shift_reg[MSB] starting SYNC_STAGES+1 clk cycles after the CS falling edge at the pin.
REQ-021 On each synchronized SCK falling edge in SHIFT, the register SHALL shift left; the bit counter SHALL increment on each synchronized SCK rising edge.
REQ-022 After the DATA_W-th rising edge, the machine SHALL enter DONE; in DONE a CS rising edge SHALL pop the head (unless the frame was an underrun), pulse frame_done, and return to IDLE.
REQ-023 A CS rising edge in SHIFT before DATA_W bits SHALL abort the frame: no pop, no frame_done, return to IDLE, and the word is retained for retransmission.
REQ-024 A push and a pop in the same cycle SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 A sample pushed in cycle N SHALL be eligible for a CS fall detected in cycle N+1 or later.
REQ-026 spi_miso SHALL be 0 whenever the synchronized CS is high.

Reset
REQ-027 When reset_n is low, the block SHALL asynchronously clear the FIFO pointers, shift register, counters and synchronizers, and force state IDLE.
REQ-028 During reset: din_ready=1, spi_miso=0, fifo_level=0, overflow=0, frame_done=0.
REQ-029 A reset in the middle of a frame SHALL discard both the frame and the FIFO contents; overflow SHALL clear only on reset.

Configuration
REQ-030 With FILTERED_TX_DROP_CNT_EN defined, the block SHALL add an 8-bit output port drop_cnt that counts dropped samples, saturates at 255 and resets to 0.
REQ-031 Without FILTERED_TX_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package filtered_tx_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and the default DATA_W, FIFO_DEPTH and SYNC_STAGES constants.
REQ-033 Storage and pointers SHALL live in one sub-module, sample_fifo, which provides push/pop/full/empty/level; the synchronizers and FSM stay in filtered_tx.

Verification
REQ-034 Push 0xA5C3, then run a 16-SCK CS frame -> MISO bits 1010010111000011, frame_done pulses once, and fifo_level goes 1->0.
REQ-035 Push 5 samples into a FIFO_DEPTH=4 FIFO -> the 5th is dropped, overflow=1, fifo_level=4, and drop_cnt=1 when the macro is enabled.
REQ-036 Run a frame with the FIFO empty -> MISO all 0, level stays 0, no pop.
REQ-037 Push 0x1234, raise CS after 7 SCKs, then run a full frame -> the abort gives no frame_done; the second frame outputs 0x1234.
REQ-038 Push and pop in the same cycle with level 2 -> level stays 2; wrap pointers over 3×FIFO_DEPTH samples -> data stays in order.
REQ-039 Assert reset_n low mid-frame at bit 9 -> outputs immediately take their reset values, and the next frame with the FIFO empty outputs zeros.
